// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bundle for the MEM-stage load/store unit.
// The master side is the pipeline plus the memory, and the slave side is the LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_is_store, req_funct3,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_misaligned, resp_fault,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_misaligned, resp_fault,
    output mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit with alignment/range checks.
// Sub-word stores are done as a read-modify-write of the containing word.
module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] MERGE = 3'd2;
  localparam logic [2:0] WR    = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic        is_store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        ill;
  logic        mis;
  logic        rng;
  logic        err;
  logic        is_sw;
  logic        mis_err;
  logic        flt_err;
  logic [31:0] word_addr;

  assign accept    = bus.req_valid && (state == IDLE);
  assign word_addr = {bus.req_addr[31:2], 2'b00};

  always_comb begin
    ill = 1'b0;
    mis = 1'b0;
    if (bus.req_is_store)
      ill = (bus.req_funct3 > 3'd2);
    else
      ill = (bus.req_funct3 == 3'd3) ||
            (bus.req_funct3[2:1] == 2'b11);
    if (bus.req_funct3[1:0] == 2'd2)
      mis = (bus.req_addr[1:0] != 2'b00);
    else if (bus.req_funct3[1:0] == 2'd1)
      mis = bus.req_addr[0];
  end

  // Faults outrank misalignment only for funct3; range comes last.
  assign rng     = (word_addr > LAST_WORD);
  assign mis_err = !ill && mis;
  assign flt_err = ill || (!mis && rng);
  assign err     = ill || mis || rng;
  assign is_sw   = !err && bus.req_is_store &&
                   (bus.req_funct3 == 3'd2);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            err:     nxt = RESP;
            is_sw:   nxt = WR;
            default: nxt = RD;
          endcase
        end
      end
      RD:      nxt = MERGE;
      MERGE:   nxt = is_store_q ? WR : RESP;
      WR:      nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] merge_data;

  assign shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = bus.mem_rdata;
    case (f3_q)
      3'd0: load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1: load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd4: load_data = {24'd0, shifted[7:0]};
      3'd5: load_data = {16'd0, shifted[15:0]};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    be   = 4'b1111;
    wrep = wdata_q;
    if (f3_q == 3'd0) begin
      be   = 4'b0001 << addr_q[1:0];
      wrep = {4{wdata_q[7:0]}};
    end else if (f3_q == 3'd1) begin
      be   = addr_q[1] ? 4'b1100 : 4'b0011;
      wrep = {2{wdata_q[15:0]}};
    end
    for (int i = 0; i < 4; i++)
      merge_data[i*8 +: 8] = be[i] ? wrep[i*8 +: 8]
                                   : bus.mem_rdata[i*8 +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      is_store_q          <= 1'b0;
      f3_q                <= 3'd0;
      addr_q              <= '0;
      wdata_q             <= '0;
      bus.req_ready       <= 1'b1;
      bus.resp_valid      <= 1'b0;
      bus.resp_rdata      <= '0;
      bus.resp_misaligned <= 1'b0;
      bus.resp_fault      <= 1'b0;
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_addr        <= '0;
      bus.mem_wdata       <= '0;
    end else begin
      state          <= nxt;
      bus.req_ready  <= (nxt == IDLE);
      bus.mem_read   <= (nxt == RD);
      bus.mem_write  <= (nxt == WR);
      bus.resp_valid <= (nxt == RESP);
      if (accept) begin
        is_store_q          <= bus.req_is_store;
        f3_q                <= bus.req_funct3;
        addr_q              <= bus.req_addr;
        wdata_q             <= bus.req_wdata;
        bus.mem_addr        <= word_addr;
        bus.mem_wdata       <= bus.req_wdata;
        bus.resp_rdata      <= '0;
        bus.resp_misaligned <= mis_err;
        bus.resp_fault      <= flt_err;
      end else if (state == MERGE) begin
        if (is_store_q)
          bus.mem_wdata <= merge_data;
        else
          bus.resp_rdata <= load_data;
      end else if (state == RESP) begin
        bus.resp_rdata      <= '0;
        bus.resp_misaligned <= 1'b0;
        bus.resp_fault      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// A small word-array memory model sits behind the unit.
module tb_load_store_unit;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_read)
      bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    if (bus.mem_write)
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int          lat;
  int          rdc;
  int          wrc;
  int          both;
  logic [31:0] rdat;
  logic        rmis;
  logic        rflt;
  logic [31:0] wcap;

  task automatic do_req(input logic st,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd);
    lat  = -1;
    rdc  = 0;
    wrc  = 0;
    rdat = 'x;
    rmis = 1'bx;
    rflt = 1'bx;
    wcap = 'x;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.mem_read) rdc++;
      if (bus.mem_write) begin
        wrc++;
        wcap = bus.mem_wdata;
      end
      if (bus.mem_read && bus.mem_write) both++;
      if (bus.resp_valid) begin
        lat  = k;
        rdat = bus.resp_rdata;
        rmis = bus.resp_misaligned;
        rflt = bus.resp_fault;
        break;
      end
    end
  endtask

  int          r1;
  int          r2;
  int          rdy1;
  int          nbusy;
  int          rv_seen;
  logic [31:0] rd2;

  initial begin
    clk    = 1'b0;
    rst    = 1'b0;
    tests  = 0;
    failed = 0;
    both   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0001;
    mem[1] = 32'h0000_0005;
    mem[2] = 32'h0000_0002;
    mem[3] = 32'h0C0C_0C0C;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'd0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_flags",
        32'({bus.resp_misaligned, bus.resp_fault}), 32'd0);
    chk("rst_strobes",
        32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    chk("rst_mwdata", bus.mem_wdata, 32'd0);
    rst = 1'b1;

    do_req(1'b0, 3'd2, 32'h4, 32'h0);
    chk("lw4_lat", 32'(lat), 32'd3);
    chk("lw4_data", rdat, 32'h0000_0005);
    chk("lw4_rd", 32'(rdc), 32'd1);
    chk("lw4_wr", 32'(wrc), 32'd0);
    chk("lw4_flags", 32'({rmis, rflt}), 32'd0);

    do_req(1'b1, 3'd2, 32'h8, 32'h0000_F080);
    chk("sw8_lat", 32'(lat), 32'd2);
    chk("sw8_strb", 32'({rdc[3:0], wrc[3:0]}), 32'h01);
    chk("sw8_wd", wcap, 32'h0000_F080);
    chk("sw8_rdata", rdat, 32'd0);
    @(negedge clk);
    chk("sw8_mem", mem[2], 32'h0000_F080);

    do_req(1'b0, 3'd0, 32'h8, 32'h0);
    chk("lb8", rdat, 32'hFFFF_FF80);
    do_req(1'b0, 3'd4, 32'h8, 32'h0);
    chk("lbu8", rdat, 32'h0000_0080);
    do_req(1'b0, 3'd1, 32'h8, 32'h0);
    chk("lh8", rdat, 32'hFFFF_F080);
    do_req(1'b0, 3'd5, 32'h8, 32'h0);
    chk("lhu8", rdat, 32'h0000_F080);
    do_req(1'b0, 3'd4, 32'h9, 32'h0);
    chk("lbu9", rdat, 32'h0000_00F0);

    do_req(1'b1, 3'd0, 32'h5, 32'h1234_56AB);
    chk("sb5_lat", 32'(lat), 32'd4);
    chk("sb5_strb", 32'({rdc[3:0], wrc[3:0]}), 32'h11);
    chk("sb5_wd", wcap, 32'h0000_AB05);
    do_req(1'b0, 3'd2, 32'h4, 32'h0);
    chk("sb5_lw", rdat, 32'h0000_AB05);

    do_req(1'b1, 3'd1, 32'h6, 32'h9999_CAFE);
    chk("sh6_wd", wcap, 32'hCAFE_AB05);
    chk("sh6_lat", 32'(lat), 32'd4);

    do_req(1'b0, 3'd1, 32'h3, 32'h0);
    chk("lh3_lat", 32'(lat), 32'd1);
    chk("lh3_flags", 32'({rmis, rflt}), 32'b10);
    chk("lh3_rdata", rdat, 32'd0);
    chk("lh3_strb", 32'(rdc + wrc), 32'd0);

    do_req(1'b0, 3'd2, 32'h400, 32'h0);
    chk("lw400_lat", 32'(lat), 32'd1);
    chk("lw400_flags", 32'({rmis, rflt}), 32'b01);
    chk("lw400_strb", 32'(rdc + wrc), 32'd0);

    do_req(1'b0, 3'd3, 32'h0, 32'h0);
    chk("f3_3_flags", 32'({rmis, rflt}), 32'b01);
    chk("f3_3_lat", 32'(lat), 32'd1);

    do_req(1'b1, 3'd3, 32'h1, 32'h0);
    chk("sf3_prio", 32'({rmis, rflt}), 32'b01);
    chk("sf3_strb", 32'(rdc + wrc), 32'd0);

    do_req(1'b1, 3'd2, 32'h3FC, 32'h5555_AAAA);
    chk("sw3fc_flags", 32'({rmis, rflt}), 32'b00);
    do_req(1'b0, 3'd2, 32'h3FC, 32'h0);
    chk("lw3fc_data", rdat, 32'h5555_AAAA);
    chk("lw3fc_lat", 32'(lat), 32'd3);

    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'd2;
    bus.req_addr     = 32'hC;
    bus.req_wdata    = 32'h7777_7777;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstwr_wr", 32'(bus.mem_write), 32'd1);
    rst = 1'b0;
    #1;
    chk("rstwr_drop", 32'(bus.mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rv_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) rv_seen++;
    end
    chk("rstwr_mem", mem[3], 32'h0C0C_0C0C);
    chk("rstwr_ready", 32'(bus.req_ready), 32'd1);
    chk("rstwr_norsp", 32'(rv_seen), 32'd0);

    r1    = 0;
    r2    = 0;
    rdy1  = 0;
    nbusy = 0;
    rd2   = 'x;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'd2;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.req_is_store = 1'b0;
    bus.req_wdata    = 32'h0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.mem_read && bus.mem_write) both++;
      if (bus.resp_valid) begin
        if (r1 == 0) r1 = k;
        else begin
          r2  = k;
          rd2 = bus.resp_rdata;
        end
      end
      if (bus.req_ready) begin
        if (rdy1 == 0) rdy1 = k;
      end else if (r2 == 0) begin
        nbusy++;
      end
      if (r2 != 0) break;
      if (bus.req_ready && rdy1 == k) begin
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_r1", 32'(r1), 32'd2);
    chk("b2b_rdy", 32'(rdy1), 32'd3);
    chk("b2b_r2", 32'(r2), 32'd6);
    chk("b2b_data", rd2, 32'hDEAD_BEEF);
    chk("b2b_busy", 32'(nbusy), 32'd4);
    chk("b2b_mem", mem[4], 32'hDEAD_BEEF);
    chk("rd_wr_excl", 32'(both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
